commit_regfile: RTL and testbench
=================================

# commit_regfile

Architectural register file with per-register busy/tag tracking, directly downstream of the reorder buffer. Retired results from the ROB commit port are written into 32 x 32-bit registers. Dispatch marks destination registers busy with the producing instruction's PC tag, which is the same PC the ROB uses to index entries. Decode reads two source operands and gets either a committed value or the tag to wait on, with same-cycle commit bypass.

## Interface
- XLEN, 32, data width
- NREG, 32, architectural registers (x0 hardwired zero)
- TAG_W, 32, tag width (instruction PC)

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- dispatch_valid  in  1  instruction with register write entering the ROB this cycle
- dispatch_rd  in  5  its destination register
- dispatch_tag  in  TAG_W  its PC
- commit_valid  in  1  ROB retires a register-writing entry
- commit_dest  in  5  retired destination
- commit_value  in  XLEN  retired value
- commit_tag  in  TAG_W  retired PC
- flush  in  1  pipeline flush; discards all speculative busy state
- rs1_addr, rs2_addr  in  5 each  source register addresses
- rs1_value, rs2_value  out  XLEN each  operand value (combinational)
- rs1_busy, rs2_busy  out  1 each  operand not yet committed
- rs1_tag, rs2_tag  out  TAG_W each  PC of pending producer; 0 when not busy
- retired_count  out  32  registered count of commits accepted

## Operation
- State: regs[NREG], busy[NREG], tag[NREG].
- Commit (commit_valid, commit_dest != 0):
  - regs[dest] <= commit_value.
  - If busy[dest] and tag[dest] == commit_tag, clear busy[dest].
  - If the tag mismatches, a younger writer is pending and busy stays set.
  - retired_count increments by 1 on every commit_valid, including dest 0. It wraps at 2^32.
- Dispatch (dispatch_valid, dispatch_rd != 0, !flush): busy[rd] <= 1 and tag[rd] <= dispatch_tag.
- Same-cycle commit and dispatch to the same rd:
  - Value is written.
  - Dispatch wins busy/tag: busy stays 1 and tag takes the new dispatch_tag.
- Flush:
  - busy[*] <= 0 next edge. Tags are left unchanged but are not observable because the read path masks tag when busy is 0.
  - A commit in the same cycle still writes its value.
  - A dispatch in the same cycle is ignored.
- x0: never written and never busy. Reads return value 0, busy 0, tag 0.
- Read path, per port, combinational, in priority order:
  1. addr == 0: value 0, busy 0, tag 0.
  2. commit_valid, commit_dest == addr, busy[addr], and tag[addr] == commit_tag (bypass): value = commit_value, busy 0, tag 0.
  3. busy[addr]: value = regs[addr], busy 1, tag = tag[addr].
  4. Otherwise: value = regs[addr], busy 0, tag 0.
- Reads never see a same-cycle dispatch. An instruction reading its own rd (e.g. add x1,x1,x2) gets the prior state.

## Timing
- Reset, asynchronous: regs, busy, tag and retired_count are all 0. Read outputs are therefore 0/0/0 while rst is high.
- Commit write is visible to reads from the next cycle; the bypass covers the same cycle.
- Dispatch busy is visible from the next cycle.
- Reset asserted mid-operation clears everything immediately. Pending commits are lost.
- No back-pressure. Every input is accepted in the cycle it is presented; up to one dispatch and one commit per cycle.

## Structure
- Shared package `core_pkg`:
  - XLEN, REG_ADDR_W = 5, TAG_W.
  - Localparam ZERO_REG = 0.
  - Typedef `reg_status_t` = {busy, tag}.
- One sub-module: `reg_status_table`, holding busy/tag update and flush.
- Value array and read mux stay in the top level.

## Test plan
- After reset, read x5 -> value 0, busy 0, tag 0, retired_count 0.
- Dispatch rd=3 tag=0x100, next cycle read x3 -> busy 1, tag 0x100. Then commit dest=3 tag=0x100 value=0xDEAD -> same-cycle read gives 0xDEAD with busy 0, and the next cycle matches.
- Dispatch x4 tag 0x10, then dispatch x4 tag 0x20, then commit x4 tag 0x10 value 7 -> read gives busy 1, tag 0x20, regs[4] = 7.
- Commit x6 tag 0x40 and dispatch x6 tag 0x44 in the same cycle, where x6 was busy with 0x40 -> next read: busy 1, tag 0x44, value = committed value.
- With x1 and x2 busy, assert flush together with dispatch x7 and commit x1 value 9 -> next cycle: all busy 0, x7 not busy, x1 = 9.
- Commit and dispatch to x0 -> x0 reads 0 and not busy; retired_count increments by 1.

Source files
------------

// File: rtl/core_pkg.sv
// Shared widths and types for the commit-side architectural register file.
// reg_status_t is the per-register scoreboard entry: busy flag plus producer PC.
package core_pkg;

   localparam int XLEN       = 32;
   localparam int NREG       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int TAG_W      = 32;

   localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [XLEN-1:0]       xlen_t;
   typedef logic [TAG_W-1:0]      tag_t;

   typedef struct packed {
      logic busy;
      tag_t tag;
   } reg_status_t;

endpackage

// File: rtl/commit_regfile_if.sv
// Dispatch, commit, flush and operand-read bundle of the commit register file.
// Every input is accepted in the cycle it is presented; there is no back-pressure.
interface commit_regfile_if;
   import core_pkg::*;

   logic      dispatch_valid;
   reg_addr_t dispatch_rd;
   tag_t      dispatch_tag;

   logic      commit_valid;
   reg_addr_t commit_dest;
   xlen_t     commit_value;
   tag_t      commit_tag;

   logic      flush;

   reg_addr_t rs1_addr;
   reg_addr_t rs2_addr;
   xlen_t     rs1_value;
   xlen_t     rs2_value;
   logic      rs1_busy;
   logic      rs2_busy;
   tag_t      rs1_tag;
   tag_t      rs2_tag;

   logic [31:0] retired_count;

   modport master (
      output dispatch_valid, dispatch_rd, dispatch_tag,
      output commit_valid, commit_dest, commit_value, commit_tag,
      output flush, rs1_addr, rs2_addr,
      input  rs1_value, rs2_value, rs1_busy, rs2_busy, rs1_tag, rs2_tag,
      input  retired_count
   );

   modport slave (
      input  dispatch_valid, dispatch_rd, dispatch_tag,
      input  commit_valid, commit_dest, commit_value, commit_tag,
      input  flush, rs1_addr, rs2_addr,
      output rs1_value, rs2_value, rs1_busy, rs2_busy, rs1_tag, rs2_tag,
      output retired_count
   );

endinterface

// File: rtl/reg_status_table.sv
// Busy/tag scoreboard: dispatch claims a register, a matching commit releases it,
// flush drops every claim. x0 is never claimed.
module reg_status_table
   import core_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        dispatch_valid_i,
   input  reg_addr_t   dispatch_rd_i,
   input  tag_t        dispatch_tag_i,
   input  logic        commit_valid_i,
   input  reg_addr_t   commit_dest_i,
   input  tag_t        commit_tag_i,
   input  logic        flush_i,
   output reg_status_t [NREG-1:0] status_o
);

   reg_status_t [NREG-1:0] status_q;
   reg_status_t [NREG-1:0] status_d;

   always_comb begin
      status_d = status_q;
      status_d[0] = '0;
      for (int i = 1; i < NREG; i++) begin
         // Priority: flush > dispatch > matching commit, so a same-cycle dispatch
         // keeps the register owned by the younger writer.
         if (flush_i) begin
            status_d[i].busy = 1'b0;
         end else if (dispatch_valid_i && (dispatch_rd_i == REG_ADDR_W'(i))) begin
            status_d[i].busy = 1'b1;
            status_d[i].tag  = dispatch_tag_i;
         end else if (commit_valid_i && (commit_dest_i == REG_ADDR_W'(i)) &&
                      status_q[i].busy && (status_q[i].tag == commit_tag_i)) begin
            status_d[i].busy = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         status_q <= '0;
      end else begin
         status_q <= status_d;
      end
   end

   assign status_o = status_q;

endmodule

// File: rtl/commit_regfile.sv
// Architectural register file written by ROB commit, with busy/tag tracking and
// same-cycle commit bypass on both combinational read ports.
module commit_regfile
   import core_pkg::*;
(
   input  logic clk,
   input  logic rst,
   commit_regfile_if.slave bus
);

   xlen_t       regs_q [NREG];
   logic [31:0] retired_count_q;
   logic [31:0] retired_count_d;

   reg_status_t [NREG-1:0] status;

   reg_status_table u_status (
      .clk              (clk),
      .rst              (rst),
      .dispatch_valid_i (bus.dispatch_valid),
      .dispatch_rd_i    (bus.dispatch_rd),
      .dispatch_tag_i   (bus.dispatch_tag),
      .commit_valid_i   (bus.commit_valid),
      .commit_dest_i    (bus.commit_dest),
      .commit_tag_i     (bus.commit_tag),
      .flush_i          (bus.flush),
      .status_o         (status)
   );

   // Commits to x0 are counted but never stored.
   assign retired_count_d = retired_count_q + (bus.commit_valid ? 32'd1 : 32'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
         retired_count_q <= '0;
      end else begin
         if (bus.commit_valid && (bus.commit_dest != ZERO_REG)) begin
            regs_q[bus.commit_dest] <= bus.commit_value;
         end
         retired_count_q <= retired_count_d;
      end
   end

   reg_addr_t raddr    [2];
   xlen_t     rd_value [2];
   logic      rd_busy  [2];
   tag_t      rd_tag   [2];

   assign raddr[0] = bus.rs1_addr;
   assign raddr[1] = bus.rs2_addr;

   always_comb begin
      reg_status_t st;
      st = '0;
      for (int p = 0; p < 2; p++) begin
         rd_value[p] = '0;
         rd_busy[p]  = 1'b0;
         rd_tag[p]   = '0;
         st = status[raddr[p]];
         if (raddr[p] != ZERO_REG) begin
            // The bypass only fires for the commit that actually releases the
            // register; a stale commit leaves the younger producer visible.
            if (bus.commit_valid && (bus.commit_dest == raddr[p]) &&
                st.busy && (st.tag == bus.commit_tag)) begin
               rd_value[p] = bus.commit_value;
            end else if (st.busy) begin
               rd_value[p] = regs_q[raddr[p]];
               rd_busy[p]  = 1'b1;
               rd_tag[p]   = st.tag;
            end else begin
               rd_value[p] = regs_q[raddr[p]];
            end
         end
      end
   end

   assign bus.rs1_value     = rd_value[0];
   assign bus.rs1_busy      = rd_busy[0];
   assign bus.rs1_tag       = rd_tag[0];
   assign bus.rs2_value     = rd_value[1];
   assign bus.rs2_busy      = rd_busy[1];
   assign bus.rs2_tag       = rd_tag[1];
   assign bus.retired_count = retired_count_q;

endmodule

// File: tb/tb_commit_regfile.sv
// Directed vector bench for commit_regfile: one table row per cycle, read ports and
// retired_count checked just before the rising edge that consumes the row.
module tb_commit_regfile;
  import core_pkg::*;

  logic clk;
  logic rst;

  commit_regfile_if bus ();

  commit_regfile dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        dv;
    logic [4:0]  rd;
    logic [31:0] dtag;
    logic        cv;
    logic [4:0]  cd;
    logic [31:0] cval;
    logic [31:0] ctag;
    logic        fl;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] e1v;
    logic        e1b;
    logic [31:0] e1t;
    logic [31:0] e2v;
    logic        e2b;
    logic [31:0] e2t;
    logic [31:0] eret;
  } vec_t;

  vec_t vecs[$];
  int n_checks;
  int n_fail;

  function automatic vec_t mk(
    logic dv, logic [4:0] rd, logic [31:0] dtag,
    logic cv, logic [4:0] cd, logic [31:0] cval, logic [31:0] ctag, logic fl,
    logic [4:0] a1, logic [31:0] e1v, logic e1b, logic [31:0] e1t,
    logic [4:0] a2, logic [31:0] e2v, logic e2b, logic [31:0] e2t,
    logic [31:0] eret);
    vec_t v;
    v.dv = dv; v.rd = rd; v.dtag = dtag;
    v.cv = cv; v.cd = cd; v.cval = cval; v.ctag = ctag; v.fl = fl;
    v.a1 = a1; v.e1v = e1v; v.e1b = e1b; v.e1t = e1t;
    v.a2 = a2; v.e2v = e2v; v.e2b = e2b; v.e2t = e2t;
    v.eret = eret;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.dispatch_valid = 1'b0; bus.dispatch_rd = '0; bus.dispatch_tag = '0;
    bus.commit_valid = 1'b0; bus.commit_dest = '0; bus.commit_value = '0; bus.commit_tag = '0;
    bus.flush = 1'b0; bus.rs1_addr = '0; bus.rs2_addr = '0;
  endtask

  task automatic apply(input vec_t v);
    bus.dispatch_valid = v.dv; bus.dispatch_rd = v.rd; bus.dispatch_tag = v.dtag;
    bus.commit_valid = v.cv; bus.commit_dest = v.cd; bus.commit_value = v.cval;
    bus.commit_tag = v.ctag; bus.flush = v.fl;
    bus.rs1_addr = v.a1; bus.rs2_addr = v.a2;
  endtask

  task automatic check_row(input string tag, input vec_t v);
    chk({tag, " rs1_value"}, bus.rs1_value, v.e1v);
    chk({tag, " rs1_busy"},  32'(bus.rs1_busy), 32'(v.e1b));
    chk({tag, " rs1_tag"},   bus.rs1_tag, v.e1t);
    chk({tag, " rs2_value"}, bus.rs2_value, v.e2v);
    chk({tag, " rs2_busy"},  32'(bus.rs2_busy), 32'(v.e2b));
    chk({tag, " rs2_tag"},   bus.rs2_tag, v.e2t);
    chk({tag, " retired_count"}, bus.retired_count, v.eret);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    drive_idle();
    rst = 1'b1;

    //        dv rd  dtag      cv cd  cval          ctag      fl  a1 e1v          b  e1t       a2 e2v          b  e2t   ret
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,            0,        0,  5, 0,            0, 0,        0, 0,            0, 0,     0));
    vecs.push_back(mk(1, 3, 32'h100,  0, 0, 0,            0,        0,  3, 0,            0, 0,        3, 0,            0, 0,     0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,            0,        0,  3, 0,            1, 32'h100,  0, 0,            0, 0,     0));
    vecs.push_back(mk(0, 0, 0,        1, 3, 32'hDEAD,     32'h100,  0,  3, 32'hDEAD,     0, 0,        3, 32'hDEAD,     0, 0,     0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,            0,        0,  3, 32'hDEAD,     0, 0,        5, 0,            0, 0,     1));
    vecs.push_back(mk(1, 4, 32'h10,   0, 0, 0,            0,        0,  4, 0,            0, 0,        3, 32'hDEAD,     0, 0,     1));
    vecs.push_back(mk(1, 4, 32'h20,   0, 0, 0,            0,        0,  4, 0,            1, 32'h10,   0, 0,            0, 0,     1));
    vecs.push_back(mk(0, 0, 0,        1, 4, 7,            32'h10,   0,  4, 0,            1, 32'h20,   3, 32'hDEAD,     0, 0,     1));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,            0,        0,  4, 7,            1, 32'h20,   0, 0,            0, 0,     2));
    vecs.push_back(mk(1, 6, 32'h40,   0, 0, 0,            0,        0,  6, 0,            0, 0,        4, 7,            1, 32'h20, 2));
    vecs.push_back(mk(1, 6, 32'h44,   1, 6, 32'h66,       32'h40,   0,  6, 32'h66,       0, 0,        4, 7,            1, 32'h20, 2));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,            0,        0,  6, 32'h66,       1, 32'h44,   0, 0,            0, 0,     3));
    vecs.push_back(mk(1, 1, 32'h200,  0, 0, 0,            0,        0,  1, 0,            0, 0,        2, 0,            0, 0,     3));
    vecs.push_back(mk(1, 2, 32'h204,  0, 0, 0,            0,        0,  1, 0,            1, 32'h200,  2, 0,            0, 0,     3));
    vecs.push_back(mk(1, 7, 32'h300,  1, 1, 9,            32'h200,  1,  1, 9,            0, 0,        2, 0,            1, 32'h204, 3));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,            0,        0,  1, 9,            0, 0,        2, 0,            0, 0,     4));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,            0,        0,  7, 0,            0, 0,        4, 7,            0, 0,     4));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,            0,        0,  6, 32'h66,       0, 0,        3, 32'hDEAD,     0, 0,     4));
    vecs.push_back(mk(1, 0, 32'h500,  1, 0, 32'h55,       32'h500,  0,  0, 0,            0, 0,        0, 0,            0, 0,     4));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,            0,        0,  0, 0,            0, 0,        6, 32'h66,       0, 0,     5));
    vecs.push_back(mk(0, 0, 0,        1, 4, 32'h44,       32'h999,  0,  4, 7,            0, 0,        0, 0,            0, 0,     5));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,            0,        0,  4, 32'h44,       0, 0,        1, 9,            0, 0,     6));

    // Outputs while reset is held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.rs1_addr = 5'd3; bus.rs2_addr = 5'd5;
    #1;
    chk("reset rs1_value", bus.rs1_value, 32'h0);
    chk("reset rs1_busy", 32'(bus.rs1_busy), 32'h0);
    chk("reset rs2_tag", bus.rs2_tag, 32'h0);
    chk("reset retired_count", bus.retired_count, 32'h0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      apply(vecs[i]);
      #1;
      check_row($sformatf("row%0d", i), vecs[i]);
    end

    // Reset asserted mid-operation wipes state at once and drops the pending commit.
    @(negedge clk);
    drive_idle();
    bus.dispatch_valid = 1'b1; bus.dispatch_rd = 5'd5; bus.dispatch_tag = 32'h77;
    @(negedge clk);
    drive_idle();
    bus.rs1_addr = 5'd5; bus.rs2_addr = 5'd3;
    #1;
    chk("pre-rst rs1_busy", 32'(bus.rs1_busy), 32'h1);
    chk("pre-rst rs1_tag", bus.rs1_tag, 32'h77);
    bus.commit_valid = 1'b1; bus.commit_dest = 5'd5;
    bus.commit_value = 32'h123; bus.commit_tag = 32'h77;
    rst = 1'b1;
    #1;
    chk("mid-rst rs1_value", bus.rs1_value, 32'h0);
    chk("mid-rst rs1_busy", 32'(bus.rs1_busy), 32'h0);
    chk("mid-rst rs2_value", bus.rs2_value, 32'h0);
    chk("mid-rst retired_count", bus.retired_count, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    bus.rs1_addr = 5'd5; bus.rs2_addr = 5'd3;
    #1;
    chk("post-rst rs1_value", bus.rs1_value, 32'h0);
    chk("post-rst rs2_value", bus.rs2_value, 32'h0);
    chk("post-rst retired_count", bus.retired_count, 32'h0);

    // Dispatch and commit to a free register together: value lands, new owner pending.
    @(negedge clk);
    bus.dispatch_valid = 1'b1; bus.dispatch_rd = 5'd9; bus.dispatch_tag = 32'hA0;
    bus.commit_valid = 1'b1; bus.commit_dest = 5'd9;
    bus.commit_value = 32'hBEEF; bus.commit_tag = 32'h90;
    bus.rs1_addr = 5'd9;
    #1;
    chk("free same-cycle rs1_busy", 32'(bus.rs1_busy), 32'h0);
    chk("free same-cycle rs1_value", bus.rs1_value, 32'h0);
    @(negedge clk);
    drive_idle();
    bus.rs1_addr = 5'd9;
    #1;
    chk("free next rs1_value", bus.rs1_value, 32'hBEEF);
    chk("free next rs1_busy", 32'(bus.rs1_busy), 32'h1);
    chk("free next rs1_tag", bus.rs1_tag, 32'hA0);
    chk("free next retired_count", bus.retired_count, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
